// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - RV32I load/store front end driving a byte-lane data RAM port
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_misaligned,
  output logic                  o_rsp_illegal,
  output logic                  o_read_req,
  output logic [ADDR_WIDTH:0]   o_read_addr,
  input  logic [31:0]           i_read_data,
  output logic                  o_write_enable,
  output logic [3:0]            o_byte_enable,
  output logic [ADDR_WIDTH:0]   o_write_addr,
  output logic [31:0]           o_write_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, LOAD_WAIT, RESP} state_t;

  state_t state, state_next;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic        fault;
  logic [3:0]  be_fmt;
  logic [31:0] data_fmt;
  logic [31:0] word_addr_full;
  logic [ADDR_WIDTH:0] word_addr;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign o_req_ready    = (state == IDLE) & ~rst;
  assign accept         = i_req_valid & o_req_ready & clk_en;
  assign word_addr_full = {2'b00, i_req_addr[31:2]};
  assign word_addr      = word_addr_full[ADDR_WIDTH:0];

  // Misalignment is only meaningful for a recognised access; unknown funct3 is illegal
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    case (i_req_funct3)
      3'b000: legal = 1'b1;
      3'b001: begin legal = 1'b1;       misaligned = i_req_addr[0];    end
      3'b010: begin legal = 1'b1;       misaligned = |i_req_addr[1:0]; end
      3'b100: legal = ~i_req_we;
      3'b101: begin legal = ~i_req_we;  misaligned = ~i_req_we & i_req_addr[0]; end
      default: ;
    endcase
  end

  assign fault = misaligned | ~legal;

  always_comb begin
    be_fmt   = 4'b1111;
    data_fmt = i_req_wdata;
    case (i_req_funct3[1:0])
      2'b00: begin
        be_fmt   = 4'b0001 << i_req_addr[1:0];
        data_fmt = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        be_fmt   = i_req_addr[1] ? 4'b1100 : 4'b0011;
        data_fmt = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = i_read_data[7:0];
    case (lane_q)
      2'd1:    load_byte = i_read_data[15:8];
      2'd2:    load_byte = i_read_data[23:16];
      2'd3:    load_byte = i_read_data[31:24];
      default: ;
    endcase
    load_half = lane_q[1] ? i_read_data[31:16] : i_read_data[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'd0, load_byte};
      3'b101:  load_ext = {16'd0, load_half};
      default: load_ext = i_read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = fault ? RESP : ISSUE;
      ISSUE:     state_next = we_q ? RESP : LOAD_WAIT;
      LOAD_WAIT: state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q             <= 1'b0;
      funct3_q         <= 3'd0;
      lane_q           <= 2'd0;
      o_rsp_valid      <= 1'b0;
      o_rsp_rdata      <= 32'd0;
      o_rsp_misaligned <= 1'b0;
      o_rsp_illegal    <= 1'b0;
      o_read_req       <= 1'b0;
      o_write_enable   <= 1'b0;
      o_byte_enable    <= 4'd0;
      o_read_addr      <= '0;
      o_write_addr     <= '0;
      o_write_data     <= 32'd0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= i_req_we;
            funct3_q <= i_req_funct3;
            lane_q   <= i_req_addr[1:0];
            if (fault) begin
              o_rsp_valid      <= 1'b1;
              o_rsp_rdata      <= 32'd0;
              o_rsp_misaligned <= misaligned;
              o_rsp_illegal    <= ~misaligned & ~legal;
            end else begin
              o_read_req     <= ~i_req_we;
              o_write_enable <= i_req_we;
              o_byte_enable  <= i_req_we ? be_fmt : 4'd0;
              o_read_addr    <= word_addr;
              o_write_addr   <= word_addr;
              if (i_req_we) o_write_data <= data_fmt;
            end
          end
        end
        ISSUE: begin
          o_read_req     <= 1'b0;
          o_write_enable <= 1'b0;
          o_byte_enable  <= 4'd0;
          if (we_q) begin
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= 32'd0;
          end
        end
        LOAD_WAIT: begin
          o_rsp_valid <= 1'b1;
          o_rsp_rdata <= load_ext;
        end
        RESP: begin
          o_rsp_valid      <= 1'b0;
          o_rsp_rdata      <= 32'd0;
          o_rsp_misaligned <= 1'b0;
          o_rsp_illegal    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
